// File: rtl/coord_scan_gen.sv
// coord_scan_gen
// Raster coordinate generator. A start request latches an origin, per-pixel
// and per-line steps and a column/row count. The block then streams one
// (x, y) beat per pixel over a valid/ready handshake, with start-of-frame,
// end-of-line and end-of-frame markers. A one-cycle done pulse follows the
// final accepted beat.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   start, abort       : begin a frame scan / drop the scan in progress
//   x_origin, y_origin : coordinate of the first pixel
//   x_step, y_step     : two's-complement increments per pixel / per line
//   n_cols, n_rows     : frame size in pixels per line and lines per frame
//   m_valid, m_ready   : coordinate beat handshake
//   m_x, m_y           : coordinate of the current beat
//   m_sof, m_eol, m_eof: frame and line markers on the current beat
//   busy, done         : scan in progress / one-cycle completion pulse
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; no beat presented
// RUN   | presenting beats; counters track column/row of the current beat
// DONE  | frame finished; done is high for this single cycle
module coord_scan_gen #(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_origin,
    input  logic [COORD_W-1:0] y_origin,
    input  logic [COORD_W-1:0] x_step,
    input  logic [COORD_W-1:0] y_step,
    input  logic [CNT_W-1:0]   n_cols,
    input  logic [CNT_W-1:0]   n_rows,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [COORD_W-1:0] m_x,
    output logic [COORD_W-1:0] m_y,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] x_origin_q, x_origin_d;
    logic [COORD_W-1:0] x_step_q, x_step_d;
    logic [COORD_W-1:0] y_step_q, y_step_d;
    logic [CNT_W-1:0]   n_cols_q, n_cols_d;
    logic [CNT_W-1:0]   n_rows_q, n_rows_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic               m_valid_q, m_valid_d;
    logic [COORD_W-1:0] m_x_q, m_x_d;
    logic [COORD_W-1:0] m_y_q, m_y_d;
    logic               m_sof_q, m_sof_d;
    logic               m_eol_q, m_eol_d;
    logic               m_eof_q, m_eof_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               col_last;
    logic               row_last;

    assign col_last = (col_q == (n_cols_q - CNT_W'(1)));
    assign row_last = (row_q == (n_rows_q - CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        x_origin_d = x_origin_q;
        x_step_d   = x_step_q;
        y_step_d   = y_step_q;
        n_cols_d   = n_cols_q;
        n_rows_d   = n_rows_q;
        col_d      = col_q;
        row_d      = row_q;
        m_valid_d  = m_valid_q;
        m_x_d      = m_x_q;
        m_y_d      = m_y_q;
        m_sof_d    = m_sof_q;
        m_eol_d    = m_eol_q;
        m_eof_d    = m_eof_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_origin_d = x_origin;
                    x_step_d   = x_step;
                    y_step_d   = y_step;
                    n_cols_d   = n_cols;
                    n_rows_d   = n_rows;
                    col_d      = '0;
                    row_d      = '0;
                    if ((n_cols == '0) || (n_rows == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        m_valid_d = 1'b1;
                        m_x_d     = x_origin;
                        m_y_d     = y_origin;
                        m_sof_d   = 1'b1;
                        m_eol_d   = (n_cols == CNT_W'(1));
                        m_eof_d   = (n_cols == CNT_W'(1)) && (n_rows == CNT_W'(1));
                    end
                end
            end

            S_RUN: begin
                if (m_valid_q && m_ready) begin
                    if (m_eof_q) begin
                        state_d   = S_DONE;
                        m_valid_d = 1'b0;
                        m_sof_d   = 1'b0;
                        m_eol_d   = 1'b0;
                        m_eof_d   = 1'b0;
                    end else if (col_last) begin
                        // Wrap to the next line: the markers describe the
                        // beat being loaded, i.e. column 0 of row_q+1.
                        col_d   = '0;
                        row_d   = row_q + CNT_W'(1);
                        m_x_d   = x_origin_q;
                        m_y_d   = m_y_q + y_step_q;
                        m_sof_d = 1'b0;
                        m_eol_d = (n_cols_q == CNT_W'(1));
                        m_eof_d = (n_cols_q == CNT_W'(1)) &&
                                  ((row_q + CNT_W'(1)) == (n_rows_q - CNT_W'(1)));
                    end else begin
                        col_d   = col_q + CNT_W'(1);
                        m_x_d   = m_x_q + x_step_q;
                        m_sof_d = 1'b0;
                        m_eol_d = ((col_q + CNT_W'(1)) == (n_cols_q - CNT_W'(1)));
                        m_eof_d = ((col_q + CNT_W'(1)) == (n_cols_q - CNT_W'(1))) && row_last;
                    end
                end
                // A beat accepted in the abort cycle still counts; abort only
                // suppresses whatever would have been presented next.
                if (abort) begin
                    state_d   = S_IDLE;
                    m_valid_d = 1'b0;
                    m_sof_d   = 1'b0;
                    m_eol_d   = 1'b0;
                    m_eof_d   = 1'b0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                m_valid_d = 1'b0;
                m_sof_d   = 1'b0;
                m_eol_d   = 1'b0;
                m_eof_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_origin_q <= '0;
            x_step_q   <= '0;
            y_step_q   <= '0;
            n_cols_q   <= '0;
            n_rows_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            m_valid_q  <= 1'b0;
            m_x_q      <= '0;
            m_y_q      <= '0;
            m_sof_q    <= 1'b0;
            m_eol_q    <= 1'b0;
            m_eof_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_origin_q <= x_origin_d;
            x_step_q   <= x_step_d;
            y_step_q   <= y_step_d;
            n_cols_q   <= n_cols_d;
            n_rows_q   <= n_rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            m_valid_q  <= m_valid_d;
            m_x_q      <= m_x_d;
            m_y_q      <= m_y_d;
            m_sof_q    <= m_sof_d;
            m_eol_q    <= m_eol_d;
            m_eof_q    <= m_eof_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;
    assign m_eof   = m_eof_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/coord_scan_gen.md
COORD_SCAN_GEN -- requirements
Module: coord_scan_gen

Interface
REQ-001 SHALL have parameter: COORD_W, 16, width of x/y coordinate, offset and step values.
REQ-002 SHALL have parameter: CNT_W, 16, width of the column/row count configuration.
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: start  in  1  single-cycle request to begin one frame scan.
REQ-006 SHALL have port: abort  in  1  terminate current scan immediately.
REQ-007 SHALL have port: x_origin  in  COORD_W  first x coordinate of each line.
REQ-008 SHALL have port: y_origin  in  COORD_W  y coordinate of the first line.
REQ-009 SHALL have port: x_step  in  COORD_W  x increment per pixel (two's-complement).
REQ-010 SHALL have port: y_step  in  COORD_W  y increment per line (two's-complement).
REQ-011 SHALL have port: n_cols  in  CNT_W  pixels per line.
REQ-012 SHALL have port: n_rows  in  CNT_W  lines per frame.
REQ-013 SHALL have port: m_valid  out  1  coordinate beat available.
REQ-014 SHALL have port: m_ready  in  1  downstream (coordinate_recalc feed) accepts beat.
REQ-015 SHALL have port: m_x  out  COORD_W  current x coordinate.
REQ-016 SHALL have port: m_y  out  COORD_W  current y coordinate.
REQ-017 SHALL have port: m_sof  out  1  beat is first pixel of frame.
REQ-018 SHALL have port: m_eol  out  1  beat is last pixel of a line.
REQ-019 SHALL have port: m_eof  out  1  beat is last pixel of frame.
REQ-020 SHALL have port: busy  out  1  high in RUN state.
REQ-021 SHALL have port: done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-022 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-023 SHALL, in IDLE with start=1, latch all configuration inputs; configuration changes afterwards SHALL not affect the scan in progress.
REQ-024 SHALL, on start with n_cols!=0 and n_rows!=0, enter RUN and present m_valid=1, m_x=x_origin, m_y=y_origin, m_sof=1 on the next cycle (latency 1).
REQ-025 SHALL, on start with n_cols=0 or n_rows=0, go to DONE, emit no beats, pulse done next cycle.
REQ-026 SHALL transfer a beat only when m_valid&&m_ready; m_x, m_y, m_sof, m_eol, m_eof SHALL hold stable while m_valid&&!m_ready.
REQ-027 SHALL, on transfer not at end of line, present the next beat the following cycle with m_x += x_step (modulo 2^COORD_W, wrap allowed); throughput one beat per cycle with m_ready held high.
REQ-028 SHALL, on transfer at column n_cols-1, reload m_x=x_origin and set m_y += y_step (modulo 2^COORD_W); m_eol=1 on that last-column beat.
REQ-029 SHALL assert m_eof (with m_eol) only on the beat at column n_cols-1, row n_rows-1; m_sof only on column 0, row 0.
REQ-030 SHALL, on transfer of the m_eof beat, drop m_valid next cycle, enter DONE, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-031 SHALL ignore start while in RUN or DONE.
REQ-032 SHALL, on abort=1 in RUN, return to IDLE next cycle with m_valid=0, no done pulse; a beat handshaked in the abort cycle counts as transferred; abort in IDLE/DONE has no effect.
REQ-033 SHALL use internal column/row counters of CNT_W bits, independent of coordinate values, so coordinate wrap never alters beat count (total beats = n_cols*n_rows).
REQ-034 SHALL keep m_sof/m_eol/m_eof at 0 whenever m_valid=0.

Reset
REQ-035 SHALL, while rst=1, force IDLE, m_valid=0, m_x=0, m_y=0, m_sof=0, m_eol=0, m_eof=0, busy=0, done=0, counters=0.
REQ-036 SHALL, on rst mid-scan, abandon the frame without done pulse; first cycle after rst deasserts SHALL be IDLE accepting start.
REQ-037 SHALL give rst priority over start and abort.

Verification
REQ-038 SHALL cover: n_cols=3, n_rows=2, origin (10,20), step (1,1), m_ready=1 -> beats (10,20)(11,20)(12,20)(10,21)(11,21)(12,21) on consecutive cycles, eol on beats 3 and 6, eof on beat 6, done 1 cycle later.
REQ-039 SHALL cover: same config, m_ready random 50% -> identical sequence, outputs stable during stalls, done after last accept.
REQ-040 SHALL cover: x_origin=0xFFFE, x_step=1, n_cols=4 -> m_x 0xFFFE,0xFFFF,0x0000,0x0001; exactly 4 beats per line.
REQ-041 SHALL cover: n_rows=0 with start -> no m_valid, done pulse one cycle after DONE entry, busy stays 0.
REQ-042 SHALL cover: abort at beat 2 of 6 -> m_valid=0 next cycle, no done; new start then yields full 6-beat frame with sof on first beat.
REQ-043 SHALL cover: rst asserted mid-frame and start pulsed during RUN -> all outputs 0 during rst; mid-RUN start ignored (beat count unchanged).
